spi_slave_gen: RTL and testbench

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_slave_pkg.sv | 11 +
 rtl/spi_shifter.sv | 22 ++
 rtl/spi_slave_gen.sv | 98 +++++++++
 tb/tb_spi_slave_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM state type, SPI command codes and FRAME_W helper shared by the spi_slave_gen slice
package spi_slave_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction
endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: parallel-load shift register, MSB/LSB-first; ports clk rst_n load load_data shift ser_in -> nxt (next shifted value) ser_out
module spi_shifter #(
  parameter int W = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         ser_in,
  output logic [W-1:0] nxt,
  output logic         ser_out
);
  logic [W-1:0] q;
  assign nxt = LSB_FIRST != 0 ? {ser_in, q[W-1:1]} : {q[W-2:0], ser_in};
  assign ser_out = LSB_FIRST != 0 ? q[0] : q[W-1];
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= load_data;
    else if (shift) q <= nxt;
endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave for {cmd[1:0],payload} frames with read-data reply; ports clk rst_n SS_n MOSI MISO rx_data rx_valid tx_data tx_valid frame_err
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LSB_FIRST = 0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);
  localparam int FW = frame_w(DATA_W);
  localparam int CW = $clog2(FW + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] wcnt, wcnt_d;
  logic [1:0] cmd, cmd_d;
  logic addr_pending, pend_d, rx_valid_d, frame_err_d, rx_upd, load, shift, ser_out;
  logic [DATA_W-1:0] nxt;
  spi_shifter #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_shift (
    .clk, .rst_n, .load, .load_data(tx_data), .shift, .ser_in(MOSI), .nxt, .ser_out
  );
  assign MISO = state == SEND && ser_out;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    wcnt_d = '0;
    cmd_d = cmd;
    pend_d = addr_pending;
    rx_valid_d = 1'b0;
    frame_err_d = 1'b0;
    rx_upd = 1'b0;
    load = 1'b0;
    shift = 1'b0;
    if (state != IDLE && SS_n) begin
      state_d = IDLE;
      cnt_d = '0;
      frame_err_d = state == RECV || state == WAIT_TX || state == SEND;
    end else begin
      case (state)
        IDLE: state_d = SS_n ? IDLE : RECV;
        RECV: begin
          cnt_d = cnt + CW'(1);
          if (cnt < CW'(2)) cmd_d = LSB_FIRST != 0 ? {MOSI, cmd[1]} : {cmd[0], MOSI};
          else shift = 1'b1;
          if (cnt == CW'(FW - 1)) begin
            cnt_d = '0;
            rx_valid_d = 1'b1;
            rx_upd = 1'b1;
            state_d = cmd == CMD_RD_DATA ? WAIT_TX : DONE;
            pend_d = cmd == CMD_RD_ADDR ? 1'b1 : cmd == CMD_RD_DATA ? 1'b0 : addr_pending;
            frame_err_d = cmd == CMD_RD_DATA && !addr_pending;
          end
        end
        WAIT_TX: begin
          wcnt_d = wcnt + 8'd1;
          load = tx_valid;
          state_d = tx_valid ? SEND : wcnt == 8'(TX_TIMEOUT - 1) ? DONE : WAIT_TX;
          frame_err_d = !tx_valid && wcnt == 8'(TX_TIMEOUT - 1);
        end
        SEND: begin
          shift = 1'b1;
          cnt_d = cnt == CW'(DATA_W - 1) ? '0 : cnt + CW'(1);
          state_d = cnt == CW'(DATA_W - 1) ? DONE : SEND;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      cmd <= '0;
      addr_pending <= 1'b0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      rx_data <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      wcnt <= wcnt_d;
      cmd <= cmd_d;
      addr_pending <= pend_d;
      rx_valid <= rx_valid_d;
      frame_err <= frame_err_d;
      if (rx_upd) rx_data <= {cmd, nxt};
    end
endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: scoreboard bench for spi_slave_gen in two configurations (8-bit MSB-first, 16-bit LSB-first)
module tb_spi_slave_gen;
  typedef struct {int e; logic [33:0] d;} rx_ev_t;
  logic clk, rst_n, ss, mosi, txv, sel_b, run;
  logic [31:0] txd;
  logic ss_a, ss_b, miso_a, miso_b, rxv_a, rxv_b, fe_a, fe_b;
  logic [9:0] rxd_a;
  logic [17:0] rxd_b;
  logic miso_s, rxv_s, fe_s;
  logic [33:0] rxd_s, held_rx;
  int checks, errors, ecnt, dw, tmo;
  bit lsb, pend;
  rx_ev_t rxq[$];
  int errq[$];
  bit exp_miso[int];

  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(0), .TX_TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi), .MISO(miso_a), .rx_data(rxd_a),
    .rx_valid(rxv_a), .tx_data(txd[7:0]), .tx_valid(txv), .frame_err(fe_a)
  );
  spi_slave_gen #(.DATA_W(16), .LSB_FIRST(1), .TX_TIMEOUT(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi), .MISO(miso_b), .rx_data(rxd_b),
    .rx_valid(rxv_b), .tx_data(txd[15:0]), .tx_valid(txv), .frame_err(fe_b)
  );

  assign ss_a = sel_b ? 1'b1 : ss;
  assign ss_b = sel_b ? ss : 1'b1;
  assign miso_s = sel_b ? miso_b : miso_a;
  assign rxv_s = sel_b ? rxv_b : rxv_a;
  assign fe_s = sel_b ? fe_b : fe_a;
  assign rxd_s = sel_b ? 34'(rxd_b) : 34'(rxd_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rb();
    return $urandom_range(0, 1) == 1;
  endfunction
  function automatic logic [31:0] msk();
    return (32'd1 << dw) - 32'd1;
  endfunction
  function automatic logic fbit(input logic [1:0] c, input logic [31:0] p, input int i);
    if (i < 2) return lsb ? c[i] : c[1-i];
    return lsb ? p[i-2] : p[dw-1-(i-2)];
  endfunction
  function automatic logic tbit(input logic [31:0] d, input int j);
    return lsb ? d[j] : d[dw-1-j];
  endfunction

  task automatic step(input logic s, input logic m, input logic v, input logic [31:0] d);
    ss = s; mosi = m; txv = v; txd = d;
    @(posedge clk);
    #1 ecnt++;
  endtask
  task automatic chk(input string nm, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask
  task automatic clear_miso(input int e);
    for (int k = e; k < e + 40; k++) if (exp_miso.exists(k)) exp_miso.delete(k);
  endtask

  task automatic frame(input logic [1:0] c, input logic [31:0] p, input int ab_rx, input int ab_wait,
                       input int ab_send, input int rs_send, input int dly, input logic [31:0] td);
    int fw, l;
    fw = dw + 2;
    step(0, rb(), rb(), $urandom);
    for (int i = 0; i < fw; i++) begin
      if (i == ab_rx) begin
        errq.push_back(ecnt + 1);
        step(1, rb(), rb(), $urandom);
        return;
      end
      if (i == fw - 1) begin
        rxq.push_back('{ecnt + 1, (34'(c) << dw) | 34'(p)});
        if (c == 2'b11 && !pend) errq.push_back(ecnt + 1);
      end
      step(0, fbit(c, p, i), rb(), $urandom);
    end
    if (c == 2'b10) pend = 1'b1;
    else if (c == 2'b11) pend = 1'b0;
    if (c == 2'b11) begin
      for (int k = 0; k < tmo; k++) begin
        if (k == ab_wait) begin
          errq.push_back(ecnt + 1);
          step(1, rb(), rb(), $urandom);
          return;
        end
        if (k == dly) begin
          l = ecnt + 1;
          for (int j = 0; j < dw; j++) exp_miso[l + j] = tbit(td, j);
          step(0, rb(), 1'b1, td);
          for (int m = 0; m < dw; m++) begin
            if (m == rs_send) begin
              clear_miso(ecnt + 1);
              rst_n = 1'b0;
              step(0, rb(), rb(), $urandom);
              rst_n = 1'b1;
              held_rx = '0;
              pend = 1'b0;
              step(1, rb(), rb(), $urandom);
              return;
            end
            if (m == ab_send) begin
              clear_miso(ecnt + 1);
              errq.push_back(ecnt + 1);
              step(1, rb(), rb(), $urandom);
              return;
            end
            step(0, rb(), rb(), $urandom);
          end
          break;
        end
        if (k == tmo - 1) errq.push_back(ecnt + 1);
        step(0, rb(), 1'b0, $urandom);
      end
    end
    repeat ($urandom_range(0, 2)) step(0, rb(), rb(), $urandom);
    step(1, rb(), rb(), $urandom);
    repeat ($urandom_range(0, 1)) step(1, rb(), rb(), $urandom);
  endtask

  task automatic rand_frames(input int n);
    int r;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 9));
      frame(2'($urandom), $urandom & msk(),
            r == 0 ? int'($urandom_range(0, dw + 1)) : -1,
            r == 1 ? int'($urandom_range(0, 3)) : -1,
            r == 2 ? int'($urandom_range(0, dw - 2)) : -1,
            r == 3 ? int'($urandom_range(0, dw - 1)) : -1,
            int'($urandom_range(0, tmo + 2)), $urandom & msk());
    end
  endtask

  always @(negedge clk) if (run) begin
    checks++;
    if (miso_s !== (exp_miso.exists(ecnt) ? exp_miso[ecnt] : 1'b0)) begin
      errors++;
      $display("FAIL miso edge %0d got %b exp %b", ecnt, miso_s, exp_miso.exists(ecnt) ? exp_miso[ecnt] : 1'b0);
    end
    if (rxv_s) begin
      checks++;
      if (rxq.size() != 0 && rxq[0].e == ecnt) begin
        held_rx = rxq[0].d;
        if (rxd_s !== rxq[0].d) begin
          errors++;
          $display("FAIL rx_data edge %0d got %h exp %h", ecnt, rxd_s, rxq[0].d);
        end
        void'(rxq.pop_front());
      end else begin
        errors++;
        $display("FAIL rx_valid edge %0d got 1 exp 0", ecnt);
      end
    end else if (rxq.size() != 0 && rxq[0].e <= ecnt) begin
      checks++;
      errors++;
      $display("FAIL rx_valid edge %0d got 0 exp 1", ecnt);
      void'(rxq.pop_front());
    end
    if (fe_s) begin
      checks++;
      if (errq.size() != 0 && errq[0] == ecnt) void'(errq.pop_front());
      else begin
        errors++;
        $display("FAIL frame_err edge %0d got 1 exp 0", ecnt);
      end
    end else if (errq.size() != 0 && errq[0] <= ecnt) begin
      checks++;
      errors++;
      $display("FAIL frame_err edge %0d got 0 exp 1", ecnt);
      void'(errq.pop_front());
    end
    checks++;
    if (rxd_s !== held_rx) begin
      errors++;
      $display("FAIL rx_hold edge %0d got %h exp %h", ecnt, rxd_s, held_rx);
    end
  end

  initial begin
    checks = 0; errors = 0; ecnt = 0; run = 1'b0; pend = 1'b0; held_rx = '0;
    sel_b = 1'b0; dw = 8; lsb = 1'b0; tmo = 16;
    rst_n = 1'b0; ss = 1'b1; mosi = 1'b0; txv = 1'b0; txd = '0;
    repeat (3) step(0, rb(), rb(), $urandom);
    chk("rst_miso_a", 34'(miso_a), 0);
    chk("rst_rxv_a", 34'(rxv_a), 0);
    chk("rst_fe_a", 34'(fe_a), 0);
    chk("rst_rxd_a", 34'(rxd_a), 0);
    chk("rst_miso_b", 34'(miso_b), 0);
    chk("rst_rxv_b", 34'(rxv_b), 0);
    chk("rst_fe_b", 34'(fe_b), 0);
    chk("rst_rxd_b", 34'(rxd_b), 0);
    rst_n = 1'b1;
    step(1, 1'b0, 1'b0, 0);
    run = 1'b1;
    frame(2'b00, 32'hA5, -1, -1, -1, -1, 0, 0);
    frame(2'b10, 32'h03, -1, -1, -1, -1, 0, 0);
    frame(2'b11, 32'h5C, -1, -1, -1, -1, 2, 32'hC3);
    frame(2'b10, 32'h11, -1, -1, -1, -1, 0, 0);
    frame(2'b11, 32'h22, -1, -1, -1, -1, 99, 0);
    frame(2'b01, 32'h77, 5, -1, -1, -1, 0, 0);
    frame(2'b01, 32'h5A, -1, -1, -1, -1, 0, 0);
    frame(2'b10, 32'h40, -1, -1, -1, -1, 0, 0);
    frame(2'b11, 32'h00, -1, -1, -1, 3, 0, 32'hF0);
    frame(2'b11, 32'h81, -1, -1, -1, -1, 1, 32'h96);
    rand_frames(60);
    repeat (2) step(1, rb(), rb(), $urandom);
    sel_b = 1'b1; dw = 16; lsb = 1'b1; tmo = 5; held_rx = '0; pend = 1'b0;
    repeat (2) step(1, rb(), rb(), $urandom);
    frame(2'b01, 32'hBEEF, -1, -1, -1, -1, 0, 0);
    frame(2'b10, 32'h0123, -1, -1, -1, -1, 0, 0);
    frame(2'b11, 32'h4321, -1, -1, -1, -1, 1, 32'h8001);
    frame(2'b11, 32'hFFFF, -1, -1, -1, -1, 99, 0);
    rand_frames(40);
    repeat (3) step(1, rb(), rb(), $urandom);
    run = 1'b0;
    chk("events_pending", 34'(rxq.size() + errq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
